spi_master_tx: RTL and testbench

- Parametrised SPI transmit master: next generation of the 8-bit sender.
- Generates its own SCLK and CS_N from the system clock.
- Supports configurable word width, all four SPI modes, MSB/LSB-first order and a programmable clock divider.
- One-word holding buffer with valid/ready handshake, so the controller can queue the next word during a transfer and get back-to-back frames under one CS_N assertion.

---
 rtl/spi_master_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_master_tx.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : spi_master_tx                                           |
// | Brief    : Parametrised SPI transmit master. One-word holding      |
// |            buffer with valid/ready handshake, all four SPI modes,  |
// |            MSB/LSB-first order and a programmable SCLK divider.    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module spi_master_tx #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic [WIDTH-1:0]     DATA,
  input  logic                 WRITE,
  output logic                 READY,
  input  logic [DIV_WIDTH-1:0] CLK_DIV,
  input  logic                 CPOL,
  input  logic                 CPHA,
  input  logic                 LSB_FIRST,
  output logic                 SCLK,
  output logic                 MOSI,
  output logic                 CS_N,
  output logic                 FULL_STATE,
  output logic                 EMPTY_STATE,
  output logic                 DONE
);

  localparam int                EDGE_W    = $clog2(2*WIDTH+1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_TRAIL = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [EDGE_W-1:0]    edge_q, edge_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [WIDTH-1:0]     buf_q, buf_d;
  logic                 full_q, full_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 cs_n_q, cs_n_d;
  logic                 done_q, done_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic                 lsb_q, lsb_d;

  logic                 w_tick;
  logic                 w_load;
  logic [EDGE_W-1:0]    w_edge_nxt;
  logic                 w_out_bit;
  logic [WIDTH-1:0]     w_shifted;
  logic                 w_ld_bit;
  logic [WIDTH-1:0]     w_ld_shifted;

  // Next serial bit and zero-filled shifted image, for the running word and for a word being loaded.
  always_comb begin
    w_out_bit    = lsb_q ? shift_q[0] : shift_q[WIDTH-1];
    w_shifted    = lsb_q ? (shift_q >> 1) : (shift_q << 1);
    w_ld_bit     = LSB_FIRST ? buf_q[0] : buf_q[WIDTH-1];
    w_ld_shifted = LSB_FIRST ? (buf_q >> 1) : (buf_q << 1);
  end

  // Next-state logic: handshake, tick counter, frame sequencing and serial outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    edge_d     = edge_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    full_d     = full_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    done_d     = 1'b0;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    w_load     = 1'b0;
    w_tick     = (cnt_q == div_q);
    w_edge_nxt = edge_q + EDGE_W'(1);

    // A write is only taken while the buffer is empty, so it can never collide with a load.
    if (WRITE && !full_q) begin
      buf_d  = DATA;
      full_d = 1'b1;
    end

    if (state_q != S_IDLE) begin
      cnt_d = w_tick ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        sclk_d = CPOL;
        cs_n_d = 1'b1;
        mosi_d = 1'b0;
        if (full_q) begin
          w_load = 1'b1;
        end
      end
      S_LEAD: begin
        sclk_d = cpol_q;
        if (w_tick) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_tick) begin
          sclk_d = ~sclk_q;
          edge_d = w_edge_nxt;
          if (w_edge_nxt[0]) begin
            // Odd (leading) edge: launches data only in CPHA=1.
            if (cpha_q) begin
              mosi_d  = w_out_bit;
              shift_d = w_shifted;
            end
          end else if (!cpha_q && (w_edge_nxt != LAST_EDGE)) begin
            // Even (trailing) edge: launches the next bit in CPHA=0, except after the last sample.
            mosi_d  = w_out_bit;
            shift_d = w_shifted;
          end
          if (w_edge_nxt == LAST_EDGE) begin
            sclk_d  = cpol_q;
            edge_d  = '0;
            state_d = S_TRAIL;
          end
        end
      end
      S_TRAIL: begin
        if (w_tick) begin
          done_d = 1'b1;
          if (full_q) begin
            w_load = 1'b1;
          end else begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            sclk_d  = CPOL;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Move the buffered word into the shifter and latch the frame configuration with it.
    if (w_load) begin
      state_d = S_LEAD;
      cs_n_d  = 1'b0;
      full_d  = 1'b0;
      buf_d   = '0;
      cnt_d   = '0;
      edge_d  = '0;
      sclk_d  = CPOL;
      cpol_d  = CPOL;
      cpha_d  = CPHA;
      lsb_d   = LSB_FIRST;
      div_d   = CLK_DIV;
      if (CPHA) begin
        shift_d = buf_q;
      end else begin
        mosi_d  = w_ld_bit;
        shift_d = w_ld_shifted;
      end
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      shift_q <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
    end
  end

  assign READY       = ~full_q;
  assign FULL_STATE  = full_q;
  assign EMPTY_STATE = (state_q == S_IDLE) && !full_q;
  assign SCLK        = sclk_q;
  assign MOSI        = mosi_q;
  assign CS_N        = cs_n_q;
  assign DONE        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_spi_master_tx                                        |
// | Brief    : Self-checking bench for spi_master_tx: frame-level      |
// |            reference model plus directed and random stimulus.     |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_spi_master_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic CLR;

  // 8-bit instance
  logic [7:0]  data_a;
  logic        write_a, ready_a;
  logic [7:0]  div_a;
  logic        cpol_a, cpha_a, lsb_a;
  logic        sclk_a, mosi_a, cs_n_a, full_a, empty_a, done_a;

  // 16-bit instance
  logic [15:0] data_b;
  logic        write_b, ready_b;
  logic [7:0]  div_b;
  logic        cpol_b, cpha_b, lsb_b;
  logic        sclk_b, mosi_b, cs_n_b, full_b, empty_b, done_b;

  spi_master_tx #(.WIDTH(8), .DIV_WIDTH(8)) u_dut_a (
    .CLK(clk), .CLR(CLR), .DATA(data_a), .WRITE(write_a), .READY(ready_a),
    .CLK_DIV(div_a), .CPOL(cpol_a), .CPHA(cpha_a), .LSB_FIRST(lsb_a),
    .SCLK(sclk_a), .MOSI(mosi_a), .CS_N(cs_n_a), .FULL_STATE(full_a),
    .EMPTY_STATE(empty_a), .DONE(done_a)
  );

  spi_master_tx #(.WIDTH(16), .DIV_WIDTH(8)) u_dut_b (
    .CLK(clk), .CLR(CLR), .DATA(data_b), .WRITE(write_b), .READY(ready_b),
    .CLK_DIV(div_b), .CPOL(cpol_b), .CPHA(cpha_b), .LSB_FIRST(lsb_b),
    .SCLK(sclk_b), .MOSI(mosi_b), .CS_N(cs_n_b), .FULL_STATE(full_b),
    .EMPTY_STATE(empty_b), .DONE(done_b)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- frame-level reference model (8-bit instance) ----------------
  // A frame is a window of 18*(div+1) cycles with CS_N low; inside it everything
  // follows from the half-period index, so only frame start times are tracked.
  int         cyc;
  bit         f_act;
  int         f_start, f_half;
  logic [7:0] f_word;
  bit         f_cpol, f_cpha, f_lsb;
  bit         m_full;
  logic [7:0] m_buf;
  bit         m_sclk_idle;
  int         done_cyc;

  always @(posedge clk or posedge CLR) begin
    bit wr_acc, start;
    if (CLR) begin
      cyc = 0; f_act = 0; f_start = 0; f_half = 1; f_word = 8'h00;
      f_cpol = 0; f_cpha = 0; f_lsb = 0;
      m_full = 0; m_buf = 8'h00; m_sclk_idle = 0; done_cyc = -1;
    end else begin
      wr_acc = write_a && !m_full;
      start  = 0;
      if (f_act) begin
        if (cyc == f_start + 18*f_half - 1) begin
          done_cyc = cyc + 1;
          if (m_full) start = 1;
          else        f_act = 0;
        end
      end else if (m_full) begin
        start = 1;
      end
      if (start) begin
        f_act = 1; f_start = cyc + 1; f_half = int'(div_a) + 1; f_word = m_buf;
        f_cpol = cpol_a; f_cpha = cpha_a; f_lsb = lsb_a; m_full = 0;
      end
      if (wr_acc) begin
        m_buf = data_a; m_full = 1;
      end
      m_sclk_idle = cpol_a;
      cyc++;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    int p, h, ed, idx;
    logic es, em, ec;
    bit chk_m;
    if (CLR) return;
    idx = 0; chk_m = 1; em = 1'b0;
    if (f_act) begin
      p  = cyc - f_start;
      h  = p / f_half;
      ed = (h == 0) ? 0 : h - 1;
      es = f_cpol ^ ed[0];
      ec = 1'b0;
      if (f_cpha) begin
        if (ed == 0) chk_m = 0;
        else         idx = (ed - 1) / 2;
      end else begin
        idx = ed / 2;
      end
      if (idx > 7) idx = 7;
      em = f_lsb ? f_word[idx] : f_word[7-idx];
    end else begin
      es = m_sclk_idle;
      ec = 1'b1;
    end
    check("cs_n", cs_n_a, ec);
    check("sclk", sclk_a, es);
    if (chk_m) check("mosi", mosi_a, em);
    check("ready", ready_a, !m_full);
    check("full", full_a, m_full);
    check("empty", empty_a, !f_act && !m_full);
    check("done", done_a, cyc == done_cyc);
  endtask

  // ---------------- frame monitors ----------------
  bit         a_prev_sclk = 0, a_prev_cs = 1;
  int         a_run = 0, a_edges = 0;
  logic [7:0] a_cap = 8'h00;
  int         a_runs[$];
  logic [7:0] a_words[$];
  int         a_done_t[$];

  bit          b_prev_sclk = 0;
  int          b_run = 0, b_edges = 0, b_done_n = 0;
  logic [15:0] b_cap = 16'h0000;

  task automatic monitor_cycle();
    if (!cs_n_a) begin
      a_run++;
      if (sclk_a != a_prev_sclk) begin
        a_edges++;
        if (sclk_a == ~(cpol_a ^ cpha_a)) a_cap = {a_cap[6:0], mosi_a};
      end
    end else if (!a_prev_cs) begin
      a_runs.push_back(a_run);
      a_run = 0; a_edges = 0;
    end
    if (done_a) begin
      a_words.push_back(a_cap);
      a_done_t.push_back(cyc);
    end
    a_prev_sclk = sclk_a;
    a_prev_cs   = cs_n_a;
    // 16-bit instance runs mode 1: samples on falling edges.
    if (!cs_n_b) begin
      b_run++;
      if (sclk_b != b_prev_sclk) begin
        b_edges++;
        if (sclk_b == 1'b0) b_cap = {b_cap[14:0], mosi_b};
      end
    end
    if (done_b) b_done_n++;
    b_prev_sclk = sclk_b;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    a_runs.delete(); a_words.delete(); a_done_t.delete();
  endtask

  task automatic write_word(input logic [7:0] d);
    bit ok = 0;
    data_a = d; write_a = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (ready_a) begin ok = 1; step(); break; end
      step();
    end
    write_a = 1'b0;
    check("write_accepted", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (empty_a && cs_n_a) begin ok = 1; break; end
    end
    check("idle_reached", ok, 1);
    @(negedge clk); #1;
  endtask

  task automatic set_cfg(input bit pol, input bit pha, input bit lsb, input logic [7:0] dv);
    cpol_a = pol; cpha_a = pha; lsb_a = lsb; div_a = dv;
    repeat (2) step();
  endtask

  initial begin
    CLR = 1'b1;
    data_a = 8'h00; write_a = 1'b0; div_a = 8'd0; cpol_a = 1'b0; cpha_a = 1'b0; lsb_a = 1'b0;
    data_b = 16'h0000; write_b = 1'b0; div_b = 8'd0; cpol_b = 1'b0; cpha_b = 1'b1; lsb_b = 1'b0;
    fork
      begin : stim
        bit ok;
        int n_acc;
        repeat (3) step();
        // Reset state
        check("rst_cs_n", cs_n_a, 1);
        check("rst_sclk", sclk_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_ready", ready_a, 1);
        check("rst_full", full_a, 0);
        check("rst_empty", empty_a, 1);
        check("rst_done", done_a, 0);
        CLR = 1'b0;
        step();

        // Mode 0, divider 0, single word
        set_cfg(0, 0, 0, 8'd0);
        clear_mon();
        write_word(8'hA5);
        wait_idle();
        check("m0_cs_low", (a_runs.size() > 0) ? a_runs[0] : -1, 18);
        check("m0_word", (a_words.size() > 0) ? a_words[0] : 8'h00, 8'hA5);
        check("m0_done_n", a_done_t.size(), 1);
        check("m0_empty", empty_a, 1);
        check("m0_sclk_end", sclk_a, 0);

        // Mode 3, LSB first, half-period 4
        set_cfg(1, 1, 1, 8'd3);
        check("m3_sclk_idle", sclk_a, 1);
        clear_mon();
        write_word(8'h01);
        wait_idle();
        check("m3_cs_low", (a_runs.size() > 0) ? a_runs[0] : -1, 72);
        check("m3_word_order", (a_words.size() > 0) ? a_words[0] : 8'h00, 8'h80);

        // Back-to-back under one CS_N
        set_cfg(0, 0, 0, 8'd0);
        clear_mon();
        write_word(8'h3C);
        write_word(8'hC3);
        wait_idle();
        check("b2b_runs", a_runs.size(), 1);
        check("b2b_cs_low", (a_runs.size() > 0) ? a_runs[0] : -1, 36);
        check("b2b_w0", (a_words.size() > 1) ? a_words[0] : 8'h00, 8'h3C);
        check("b2b_w1", (a_words.size() > 1) ? a_words[1] : 8'h00, 8'hC3);
        check("b2b_done_gap", (a_done_t.size() > 1) ? a_done_t[1] - a_done_t[0] : -1, 18);

        // Write while full is dropped
        clear_mon();
        write_word(8'h3C);
        write_word(8'h11);
        data_a = 8'h22; write_a = 1'b1;
        check("wf_ready_low", ready_a, 0);
        step();
        write_a = 1'b0;
        check("wf_full", full_a, 1);
        wait_idle();
        check("wf_words", a_words.size(), 2);
        check("wf_w1", (a_words.size() > 1) ? a_words[1] : 8'h00, 8'h11);

        // Clear in the middle of SHIFT
        clear_mon();
        write_word(8'h5A);
        write_word(8'h77);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
          @(negedge clk); #1;
          if (a_edges == 5) begin ok = 1; break; end
        end
        check("reach_edge5", ok, 1);
        CLR = 1'b1;
        #1;
        check("clr_cs_n", cs_n_a, 1);
        check("clr_sclk", sclk_a, 0);
        check("clr_mosi", mosi_a, 0);
        check("clr_full", full_a, 0);
        check("clr_ready", ready_a, 1);
        check("clr_done", done_a, 0);
        step();
        CLR = 1'b0;
        step();
        clear_mon();
        write_word(8'hFF);
        wait_idle();
        check("post_clr_cs_low", (a_runs.size() > 0) ? a_runs[0] : -1, 18);
        check("post_clr_word", (a_words.size() > 0) ? a_words[0] : 8'h00, 8'hFF);

        // 16-bit instance, mode 1
        b_edges = 0; b_run = 0; b_done_n = 0; b_cap = 16'h0000;
        data_b = 16'h8001; write_b = 1'b1;
        check("w16_ready", ready_b, 1);
        step();
        write_b = 1'b0;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
          step();
          if (b_done_n == 1) begin ok = 1; break; end
        end
        check("w16_done", ok, 1);
        check("w16_edges", b_edges, 32);
        check("w16_word", b_cap, 16'h8001);
        check("w16_cs_low", b_run, 34);
        check("w16_empty", empty_b, 1);
        check("w16_full", full_b, 0);

        // Random traffic and configuration churn
        clear_mon();
        n_acc = 0;
        for (int i = 0; i < 3000; i++) begin
          write_a = ($urandom_range(0, 2) == 0);
          data_a  = 8'($urandom);
          if ($urandom_range(0, 15) == 0) begin
            cpol_a = 1'($urandom_range(0, 1));
            cpha_a = 1'($urandom_range(0, 1));
            lsb_a  = 1'($urandom_range(0, 1));
            div_a  = 8'($urandom_range(0, 2));
          end
          if (write_a && ready_a) n_acc++;
          step();
        end
        write_a = 1'b0;
        wait_idle();
        check("rand_word_count", a_words.size(), n_acc);
      end
      forever begin
        @(negedge clk);
        monitor_cycle();
        compare_cycle();
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
